// File: rtl/sound_pkg.sv
// Shared constants for the 68K-to-Z80 sound command mailbox.
// Imported by the latch port, its IRQ timer and the bench.
package sound_pkg;

  localparam int         SND_IRQ_PERIOD   = 512;
  localparam logic [7:0] Z80_IO_LATCH_CLR = 8'h04;
  localparam logic [7:0] Z80_IO_LATCH_R   = 8'h06;
  localparam logic [7:0] OVERRUN_MAX      = 8'hFF;

endpackage

// File: rtl/sound_latch_port_if.sv
// Bus bundle between the decoder/CPUs and the sound latch port.
// master drives the CPU-side strobes, slave is the latch port.
interface sound_latch_port_if;

  logic       sound_latch_cs;
  logic       cpu_rw;
  logic       cpu_lds_n;
  logic [7:0] cpu_dout;
  logic       z80_ce;
  logic       z80_latch_r_cs;
  logic       z80_latch_clr_cs;
  logic       z80_rd_n;
  logic       M1_n;
  logic       IORQ_n;
  logic [7:0] z80_latch_dout;
  logic       latch_pending;
  logic [7:0] overrun_count;
  logic       z80_int_n;

  modport master (
    output sound_latch_cs, cpu_rw, cpu_lds_n, cpu_dout,
    output z80_ce, z80_latch_r_cs, z80_latch_clr_cs,
    output z80_rd_n, M1_n, IORQ_n,
    input  z80_latch_dout, latch_pending,
    input  overrun_count, z80_int_n
  );

  modport slave (
    input  sound_latch_cs, cpu_rw, cpu_lds_n, cpu_dout,
    input  z80_ce, z80_latch_r_cs, z80_latch_clr_cs,
    input  z80_rd_n, M1_n, IORQ_n,
    output z80_latch_dout, latch_pending,
    output overrun_count, z80_int_n
  );

endinterface

// File: rtl/sound_irq_timer.sv
// Z80 periodic interrupt: counts z80_ce pulses, holds INT low
// until an M1+IORQ acknowledge; a wrap beats a same-edge ack.
module sound_irq_timer
  import sound_pkg::*;
#(
  parameter int IRQ_PERIOD = SND_IRQ_PERIOD,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic z80_ce,
  input  logic M1_n,
  input  logic IORQ_n,
  output logic z80_int_n
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(IRQ_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             ack;

  assign wrap = z80_ce && (cnt == LAST);
  assign ack  = !M1_n && !IORQ_n;

  // Period counter, advances once per Z80 cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (z80_ce)
      cnt <= wrap ? '0 : cnt + 1'b1;
  end

  // INT hold: wrap asserts, ack releases, wrap has priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      z80_int_n <= 1'b1;
    else if (wrap)
      z80_int_n <= 1'b0;
    else if (ack)
      z80_int_n <= 1'b1;
  end

endmodule

// File: rtl/sound_latch_port.sv
// 68K-to-Z80 sound command latch with pending flag, overrun
// counter and the Z80 periodic interrupt source.
module sound_latch_port
  import sound_pkg::*;
#(
  parameter int IRQ_PERIOD = SND_IRQ_PERIOD,
  parameter int CNT_W      = 10
) (
  input logic               clk,
  input logic               reset_n,
  sound_latch_port_if.slave bus
);

  logic       wq, rq, cq;
  logic       wq_q, rq_q, cq_q;
  logic       w_ev, r_ev, c_ev;
  logic [7:0] latch;
  logic       pending;
  logic [7:0] overrun;

  assign wq = bus.sound_latch_cs && !bus.cpu_rw && !bus.cpu_lds_n;
  assign rq = bus.z80_latch_r_cs && !bus.z80_rd_n;
  assign cq = bus.z80_latch_clr_cs && !bus.z80_rd_n;

  assign w_ev = wq && !wq_q;
  assign r_ev = rq && !rq_q;
  assign c_ev = cq && !cq_q;

  // Strobe history so a held strobe yields one event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wq_q <= 1'b0;
      rq_q <= 1'b0;
      cq_q <= 1'b0;
    end else begin
      wq_q <= wq;
      rq_q <= rq;
      cq_q <= cq;
    end
  end

  // Latch and pending flag: write beats clear beats read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch   <= 8'h00;
      pending <= 1'b0;
    end else if (w_ev) begin
      latch   <= bus.cpu_dout;
      pending <= 1'b1;
    end else if (c_ev) begin
      latch   <= 8'h00;
      pending <= 1'b0;
    end else if (r_ev) begin
      pending <= 1'b0;
    end
  end

  // Overrun: a write lands on an unread byte; a same-edge
  // read consumes the old byte so it does not count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overrun <= 8'h00;
    else if (w_ev && pending && !r_ev && overrun != OVERRUN_MAX)
      overrun <= overrun + 8'd1;
  end

  assign bus.z80_latch_dout = latch;
  assign bus.latch_pending  = pending;
  assign bus.overrun_count  = overrun;

  sound_irq_timer #(
    .IRQ_PERIOD (IRQ_PERIOD),
    .CNT_W      (CNT_W)
  ) u_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .z80_ce    (bus.z80_ce),
    .M1_n      (bus.M1_n),
    .IORQ_n    (bus.IORQ_n),
    .z80_int_n (bus.z80_int_n)
  );

endmodule
